// File: rtl/jpeg_pkg.sv
// Shared JPEG front-end types: component tags, pixel beat layout and block size.
package jpeg_pkg;

  localparam int unsigned BLOCK_PIX    = 64;
  localparam int unsigned PIX_PER_BEAT = 2;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_t;

  typedef logic signed [PIX_PER_BEAT-1:0][7:0] pix_beat_t;

endpackage

// File: rtl/ycc_block_sched_if.sv
// Stream bundle for the YCbCr block scheduler: three-component input, single-component output.
interface ycc_block_sched_if;
  import jpeg_pkg::*;

  logic      in_valid;
  logic      in_ready;
  pix_beat_t in_data_y;
  pix_beat_t in_data_cb;
  pix_beat_t in_data_cr;
  logic      in_sob;
  logic      in_eob;
  logic      in_sof;

  logic      out_valid;
  logic      out_ready;
  pix_beat_t out_data;
  comp_t     out_comp;
  logic      out_sob;
  logic      out_eob;
  logic      out_sof;
  logic      err;

  modport slave (
    input  in_valid, in_data_y, in_data_cb, in_data_cr, in_sob, in_eob, in_sof, out_ready,
    output in_ready, out_valid, out_data, out_comp, out_sob, out_eob, out_sof, err
  );

  modport master (
    output in_valid, in_data_y, in_data_cb, in_data_cr, in_sob, in_eob, in_sof, out_ready,
    input  in_ready, out_valid, out_data, out_comp, out_sob, out_eob, out_sof, err
  );

endinterface

// File: rtl/blk_store.sv
// One-block chroma store: single synchronous write port, asynchronous read port.
module blk_store #(
  parameter  int unsigned DEPTH = 32,
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Contents are deliberately not reset; unwritten entries replay stale data.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ycc_block_sched.sv
// Forwards Y of each 8x8 block while capturing Cb/Cr, then replays Cb and Cr as two
// further blocks so a single transform datapath serves all three components.
module ycc_block_sched
  import jpeg_pkg::*;
#(
  parameter int unsigned N     = PIX_PER_BEAT,
  parameter int unsigned BEATS = BLOCK_PIX / N
) (
  input  logic               clk,
  input  logic               rst,
  ycc_block_sched_if.slave   bus
);

  localparam int unsigned   AW   = $clog2(BEATS);
  localparam int unsigned   W    = N * 8;
  localparam logic [AW-1:0] LAST = AW'(BEATS - 1);

  typedef enum logic [1:0] {
    S_Y  = 2'd0,
    S_CB = 2'd1,
    S_CR = 2'd2
  } state_t;

  state_t        state_q;
  logic [AW-1:0] wcnt_q;
  logic [AW-1:0] rcnt_q;

  logic          adv;
  logic          accept;
  logic          sob_bad;
  logic          eob_bad;
  logic [AW-1:0] waddr;
  logic [W-1:0]  cb_rd;
  logic [W-1:0]  cr_rd;
  logic [W-1:0]  replay_data;

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (state_q == S_Y) && adv;
  assign accept       = bus.in_valid && bus.in_ready;

  // A start-of-block beat always lands at address 0, resynchronising the write counter.
  assign waddr   = bus.in_sob ? '0 : wcnt_q;
  assign sob_bad = bus.in_sob && (wcnt_q != '0);
  assign eob_bad = bus.in_eob && (wcnt_q != LAST);

  blk_store #(
    .DEPTH (BEATS),
    .WIDTH (W)
  ) u_cb_store (
    .clk   (clk),
    .we    (accept),
    .waddr (waddr),
    .wdata (bus.in_data_cb),
    .raddr (rcnt_q),
    .rdata (cb_rd)
  );

  blk_store #(
    .DEPTH (BEATS),
    .WIDTH (W)
  ) u_cr_store (
    .clk   (clk),
    .we    (accept),
    .waddr (waddr),
    .wdata (bus.in_data_cr),
    .raddr (rcnt_q),
    .rdata (cr_rd)
  );

  assign replay_data = (state_q == S_CR) ? cr_rd : cb_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_Y;
      wcnt_q        <= '0;
      rcnt_q        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_comp  <= COMP_Y;
      bus.out_sob   <= 1'b0;
      bus.out_eob   <= 1'b0;
      bus.out_sof   <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.err <= 1'b0;
      unique case (state_q)
        S_Y: begin
          if (adv) begin
            if (accept) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= bus.in_data_y;
              bus.out_comp  <= COMP_Y;
              bus.out_sob   <= bus.in_sob;
              bus.out_eob   <= bus.in_eob;
              bus.out_sof   <= bus.in_sof;
              bus.err       <= sob_bad || eob_bad;
              if (bus.in_eob) begin
                wcnt_q  <= '0;
                rcnt_q  <= '0;
                state_q <= S_CB;
              end else if (bus.in_sob) begin
                wcnt_q <= AW'(1);
              end else begin
                wcnt_q <= wcnt_q + 1'b1;
              end
            end else begin
              bus.out_valid <= 1'b0;
            end
          end
        end
        S_CB, S_CR: begin
          // Replay length is fixed at BEATS regardless of how many beats were captured.
          if (adv) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= replay_data;
            bus.out_comp  <= (state_q == S_CB) ? COMP_CB : COMP_CR;
            bus.out_sob   <= (rcnt_q == '0);
            bus.out_eob   <= (rcnt_q == LAST);
            bus.out_sof   <= 1'b0;
            rcnt_q        <= rcnt_q + 1'b1;
            if (rcnt_q == LAST) begin
              state_q <= (state_q == S_CB) ? S_CR : S_Y;
            end
          end
        end
        default: state_q <= S_Y;
      endcase
    end
  end

endmodule

// File: tb/tb_ycc_block_sched.sv
// Directed bench for ycc_block_sched: full blocks, back-pressure, framing errors, mid-replay reset.
module tb_ycc_block_sched;
  import jpeg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ycc_block_sched_if bus ();

  ycc_block_sched #(
    .N     (2),
    .BEATS (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int last_cycles = 0;

  // Expected chroma store contents and write counter, tracked from the planned input.
  logic [15:0] mem_cb [32];
  logic [15:0] mem_cr [32];
  int          mw = 0;

  logic [15:0] iy [64];
  logic [15:0] icb [64];
  logic [15:0] icr [64];
  logic        isob [64];
  logic        ieob [64];
  logic        isof [64];
  logic        ierr [64];

  logic [15:0] e_data [$];
  logic [15:0] e_comp [$];
  logic        e_sob [$];
  logic        e_eob [$];
  logic        e_sof [$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] pair(input logic [7:0] b);
    logic [7:0] p0;
    logic [7:0] p1;
    p0 = b + 8'd1;
    p1 = b + 8'd2;
    return {p1, p0};
  endfunction

  task automatic push_exp(input logic [15:0] d, input logic [15:0] c, input logic s,
                          input logic e, input logic f);
    e_data.push_back(d);
    e_comp.push_back(c);
    e_sob.push_back(s);
    e_eob.push_back(e);
    e_sof.push_back(f);
  endtask

  // Builds input beats and the full expected output sequence (Y, then 32 Cb, then 32 Cr).
  task automatic plan(input logic [7:0] base, input int n_in, input int sob2, input int eob_at,
                      input bit sof);
    int addr;
    logic [7:0] b;
    e_data.delete(); e_comp.delete(); e_sob.delete(); e_eob.delete(); e_sof.delete();
    for (int i = 0; i < n_in; i++) begin
      b       = base + 8'(2 * i);
      iy[i]   = pair(b);
      icb[i]  = pair(b + 8'h40);
      icr[i]  = pair(b + 8'h80);
      isob[i] = (i == 0) || (i == sob2);
      ieob[i] = (i == eob_at);
      isof[i] = sof && (i == 0);
      ierr[i] = (isob[i] && mw != 0) || (ieob[i] && mw != 31);
      addr    = isob[i] ? 0 : mw;
      mem_cb[addr] = icb[i];
      mem_cr[addr] = icr[i];
      mw = ieob[i] ? 0 : (isob[i] ? 1 : (mw + 1) % 32);
      push_exp(iy[i], 16'd0, isob[i], ieob[i], isof[i]);
    end
    for (int j = 0; j < 32; j++) push_exp(mem_cb[j], 16'd1, j == 0, j == 31, 1'b0);
    for (int j = 0; j < 32; j++) push_exp(mem_cr[j], 16'd2, j == 0, j == 31, 1'b0);
  endtask

  task automatic run(input int n_in, input bit rnd, input int n_out, input int limit);
    int ii = 0;
    int oi = 0;
    int cyc = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [15:0] pd = '0;
    logic [15:0] pc = '0;
    logic err_exp = 1'b0;
    while (oi < n_out && cyc < limit) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid  = (ii < n_in);
      if (ii < n_in) begin
        bus.in_data_y  = iy[ii];
        bus.in_data_cb = icb[ii];
        bus.in_data_cr = icr[ii];
        bus.in_sob     = isob[ii];
        bus.in_eob     = ieob[ii];
        bus.in_sof     = isof[ii];
      end else begin
        bus.in_data_y  = '0;
        bus.in_data_cb = '0;
        bus.in_data_cr = '0;
        bus.in_sob     = 1'b0;
        bus.in_eob     = 1'b0;
        bus.in_sof     = 1'b0;
      end
      #1;
      check("err", 16'(bus.err), 16'(err_exp));
      if (pv && !pr) begin
        check("hold_valid", 16'(bus.out_valid), 16'd1);
        check("hold_data", 16'(bus.out_data), pd);
        check("hold_comp", 16'(bus.out_comp), pc);
      end
      if (bus.out_valid && (bus.out_comp == COMP_CB || (bus.out_comp == COMP_CR && !bus.out_eob)))
        check("in_ready_replay", 16'(bus.in_ready), 16'd0);
      err_exp = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        err_exp = ierr[ii];
        ii++;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("out_data", 16'(bus.out_data), e_data[oi]);
        check("out_comp", 16'(bus.out_comp), e_comp[oi]);
        check("out_sob", 16'(bus.out_sob), 16'(e_sob[oi]));
        check("out_eob", 16'(bus.out_eob), 16'(e_eob[oi]));
        check("out_sof", 16'(bus.out_sof), 16'(e_sof[oi]));
        oi++;
      end
      pv = bus.out_valid;
      pr = bus.out_ready;
      pd = 16'(bus.out_data);
      pc = 16'(bus.out_comp);
      @(negedge clk);
      cyc++;
    end
    check("beats_done", 16'(oi), 16'(n_out));
    last_cycles = cyc;
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data_y  = '0;
    bus.in_data_cb = '0;
    bus.in_data_cr = '0;
    bus.in_sob     = 1'b0;
    bus.in_eob     = 1'b0;
    bus.in_sof     = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", 16'(bus.out_valid), 16'd0);
    check("rst_data", 16'(bus.out_data), 16'd0);
    check("rst_comp", 16'(bus.out_comp), 16'd0);
    check("rst_sob", 16'(bus.out_sob), 16'd0);
    check("rst_eob", 16'(bus.out_eob), 16'd0);
    check("rst_sof", 16'(bus.out_sof), 16'd0);
    check("rst_err", 16'(bus.err), 16'd0);
    check("rst_in_ready", 16'(bus.in_ready), 16'd1);
    @(negedge clk);

    // Nominal block with sof, ready held high: 96 back-to-back beats after 1 cycle latency.
    plan(8'h00, 32, -1, 31, 1'b1);
    run(32, 1'b0, 96, 400);
    check("throughput_cycles", 16'(last_cycles), 16'd97);

    // Same block under random back-pressure.
    plan(8'h00, 32, -1, 31, 1'b1);
    run(32, 1'b1, 96, 2000);

    // Early eob at beat 20: one err pulse, entries 21..31 replay the previous block.
    plan(8'h20, 21, -1, 20, 1'b0);
    run(21, 1'b0, 85, 400);

    // Stray sob at beat 10 rewrites address 0; eob then lands cleanly on wcnt 31.
    plan(8'h30, 42, 10, 41, 1'b0);
    run(42, 1'b1, 106, 3000);

    // Reset while Cb replay beat 7 sits in the output register.
    plan(8'h50, 32, -1, 31, 1'b0);
    run(32, 1'b0, 39, 400);
    check("pre_rst_comp", 16'(bus.out_comp), 16'd1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", 16'(bus.out_valid), 16'd0);
    check("midrst_in_ready", 16'(bus.in_ready), 16'd1);
    check("midrst_err", 16'(bus.err), 16'd0);
    mw = 0;

    // Next block after the abandoned one starts with Y.
    plan(8'h60, 32, -1, 31, 1'b0);
    run(32, 1'b0, 96, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
